sel_mux_pipe: RTL and testbench

- Parametrised registered N-way, WIDTH-bit selector with a valid/ready handshake on both sides; generalises the single-bit 8-to-1 selector in the mono-cycle MIPS datapath.
- Select source: per-transfer select input, or a latched select register (programmable mode).
- Out-of-range selects (N not a power of two) return a defined default value and set a sticky error flag.
- Sits between operand sources and the ALU / writeback path where selection must be registered and flow-controlled.

---
 rtl/sel_mux_pipe_if.sv | 31 +++
 rtl/sel_mux_pipe.sv | 95 +++++++++
 tb/tb_sel_mux_pipe.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/sel_mux_pipe_if.sv
// sel_mux_pipe_if: upstream/downstream valid-ready stream bundle for sel_mux_pipe.
//   in_valid/in_ready  : upstream handshake
//   in_data            : N channels, channel k at [k*WIDTH +: WIDTH]
//   in_sel             : per-transfer select
//   out_valid/out_ready: downstream handshake
//   out_data/out_sel   : registered selected channel and effective select
// master = producer/consumer side (testbench), slave = the selector.
interface sel_mux_pipe_if #(
  parameter int WIDTH = 32,
  parameter int N     = 8,
  parameter int SEL_W = 3
);
  logic                 in_valid;
  logic                 in_ready;
  logic [N*WIDTH-1:0]   in_data;
  logic [SEL_W-1:0]     in_sel;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_data;
  logic [SEL_W-1:0]     out_sel;

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/sel_mux_pipe.sv
// sel_mux_pipe: registered N-way WIDTH-bit selector with valid/ready flow control.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   bus        : stream interface (slave side), see sel_mux_pipe_if
//   sel_mode   : 0 selects with bus.in_sel, 1 selects with the latched register
//   sel_load   : write sel_val into the select register
//   sel_val    : value for the select register (stored unclamped)
//   cur_sel    : select register contents
//   err_sticky : an out-of-range select was accepted since the last clear
//   err_clr    : clear err_sticky (a simultaneous new error wins)
module sel_mux_pipe #(
  parameter int                 WIDTH     = 32,
  parameter int                 N         = 8,
  parameter int                 SEL_W     = 3,
  parameter logic [WIDTH-1:0]   DEFAULT   = '0,
  parameter logic [SEL_W-1:0]   RESET_SEL = '0
) (
  input  logic              clk,
  input  logic              rst,
  sel_mux_pipe_if.slave     bus,
  input  logic              sel_mode,
  input  logic              sel_load,
  input  logic [SEL_W-1:0]  sel_val,
  output logic [SEL_W-1:0]  cur_sel,
  output logic              err_sticky,
  input  logic              err_clr
);

  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q,  out_data_d;
  logic [SEL_W-1:0]  out_sel_q,   out_sel_d;
  logic [SEL_W-1:0]  cur_sel_q,   cur_sel_d;
  logic              err_q,       err_d;

  logic              accept;
  logic [SEL_W-1:0]  eff_sel;
  logic              in_range;
  logic [WIDTH-1:0]  mux_data;

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign eff_sel      = sel_mode ? cur_sel_q : bus.in_sel;
  // Widened compare so N == 2**SEL_W is handled without overflow.
  assign in_range     = 32'(eff_sel) < N;

  // Only legal channels are decoded; anything else falls through to DEFAULT.
  always_comb begin
    mux_data = DEFAULT;
    for (int unsigned k = 0; k < N; k++) begin
      if (eff_sel == SEL_W'(k)) mux_data = bus.in_data[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    cur_sel_d   = cur_sel_q;
    err_d       = err_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_data;
      out_sel_d   = eff_sel;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    // The transfer above already used cur_sel_q, so a coincident load lands next cycle.
    if (sel_load) cur_sel_d = sel_val;
    if (err_clr) err_d = 1'b0;
    if (accept && !in_range) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      cur_sel_q   <= RESET_SEL;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      cur_sel_q   <= cur_sel_d;
      err_q       <= err_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
  assign cur_sel       = cur_sel_q;
  assign err_sticky    = err_q;

endmodule

// File: tb/tb_sel_mux_pipe.sv
// tb_sel_mux_pipe: scoreboard bench for sel_mux_pipe (WIDTH=8, N=6, SEL_W=3).
// The driver advances a behavioural model and queues expected results; the
// monitor compares whatever the DUT presents on its output port.
module tb_sel_mux_pipe;
  localparam int WIDTH = 8;
  localparam int N     = 6;
  localparam int SEL_W = 3;
  localparam logic [WIDTH-1:0] DEF  = 8'h00;
  localparam logic [SEL_W-1:0] RSEL = 3'd0;

  logic clk = 1'b0;
  logic rst;
  logic sel_mode, sel_load, err_clr;
  logic [SEL_W-1:0] sel_val;
  logic [SEL_W-1:0] cur_sel;
  logic err_sticky;

  sel_mux_pipe_if #(.WIDTH(WIDTH), .N(N), .SEL_W(SEL_W)) bus ();

  sel_mux_pipe #(
    .WIDTH(WIDTH), .N(N), .SEL_W(SEL_W), .DEFAULT(DEF), .RESET_SEL(RSEL)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .sel_mode(sel_mode), .sel_load(sel_load), .sel_val(sel_val),
    .cur_sel(cur_sel), .err_sticky(err_sticky), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic [SEL_W-1:0] s;
  } item_t;

  item_t exp_q[$];
  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] chan [N];

  // Model state, as visible after the most recent clock edge.
  bit               m_valid;
  logic [WIDTH-1:0] m_data;
  logic [SEL_W-1:0] m_sel;
  logic [SEL_W-1:0] m_cur;
  bit               m_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every presented output must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        chk("mon_out_data", 32'(bus.out_data), 32'(exp_q[0].d));
        chk("mon_out_sel",  32'(bus.out_sel),  32'(exp_q[0].s));
        if (bus.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Drive one cycle of inputs, predict the edge, then check visible state.
  task automatic step(input bit r, input bit iv, input logic [SEL_W-1:0] is,
                      input bit md, input bit ld, input logic [SEL_W-1:0] sv,
                      input bit ordy, input bit clr);
    bit acc;
    int unsigned eff;
    item_t it;
    rst = r; bus.in_valid = iv; bus.in_sel = is; sel_mode = md;
    sel_load = ld; sel_val = sv; bus.out_ready = ordy; err_clr = clr;
    for (int k = 0; k < N; k++) bus.in_data[k*WIDTH +: WIDTH] = chan[k];
    #1;
    chk("in_ready", 32'(bus.in_ready), 32'(!m_valid || ordy));
    if (r) begin
      m_valid = 0; m_data = '0; m_sel = '0; m_cur = RSEL; m_err = 0;
      exp_q.delete();
    end else begin
      acc = iv && (!m_valid || ordy);
      eff = md ? int'(m_cur) : int'(is);
      if (clr) m_err = 0;
      if (acc) begin
        it.s = SEL_W'(eff);
        it.d = (eff < N) ? chan[eff] : DEF;
        exp_q.push_back(it);
        m_valid = 1; m_data = it.d; m_sel = it.s;
        if (eff >= N) m_err = 1;
      end else if (ordy) begin
        m_valid = 0;
      end
      if (ld) m_cur = sv;
    end
    @(posedge clk);
    #1;
    chk("out_valid",  32'(bus.out_valid), 32'(m_valid));
    chk("out_data",   32'(bus.out_data),  32'(m_data));
    chk("out_sel",    32'(bus.out_sel),   32'(m_sel));
    chk("cur_sel",    32'(cur_sel),       32'(m_cur));
    chk("err_sticky", 32'(err_sticky),    32'(m_err));
  endtask

  task automatic idle(input bit ordy, input bit clr);
    step(0, 0, '0, 0, 0, '0, ordy, clr);
  endtask

  initial begin
    for (int k = 0; k < N; k++) chan[k] = WIDTH'(8'h10 + k);
    m_valid = 0; m_data = '0; m_sel = '0; m_cur = RSEL; m_err = 0;
    rst = 1; sel_mode = 0; sel_load = 0; sel_val = '0; err_clr = 0;
    bus.in_valid = 0; bus.in_sel = '0; bus.out_ready = 0; bus.in_data = '0;

    // Reset; state after reset is all zero / RESET_SEL.
    step(1, 0, '0, 0, 0, '0, 0, 0);
    step(1, 1, 3'd2, 0, 1, 3'd5, 1, 0);

    // Basic select.
    step(0, 1, 3'd4, 0, 0, '0, 1, 0);
    idle(1, 0);

    // Backpressure: 0x12 held while out_ready=0, then 0x15.
    step(0, 1, 3'd2, 0, 0, '0, 1, 0);
    repeat (3) step(0, 1, 3'd5, 0, 0, '0, 0, 0);
    step(0, 1, 3'd5, 0, 0, '0, 1, 0);
    idle(1, 0);

    // Out of range, clear alone, clear coinciding with a new error.
    step(0, 1, 3'd7, 0, 0, '0, 1, 0);
    idle(1, 1);
    step(0, 1, 3'd6, 0, 0, '0, 1, 1);
    idle(1, 1);

    // Latched mode: coincident load uses old cur_sel, then the new one.
    step(0, 1, 3'd5, 1, 1, 3'd3, 1, 0);
    step(0, 1, 3'd1, 1, 0, '0, 1, 0);
    idle(1, 0);

    // Full throughput.
    for (int i = 0; i < N; i++) step(0, 1, SEL_W'(i), 0, 0, '0, 1, 0);
    idle(1, 0);

    // Mid-stream reset discards the pending result.
    step(0, 1, 3'd1, 0, 0, '0, 1, 0);
    idle(0, 0);
    step(1, 0, '0, 0, 0, '0, 0, 0);
    idle(1, 0);
    idle(1, 0);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0)
        for (int k = 0; k < N; k++) chan[k] = WIDTH'($urandom);
      step(($urandom_range(0, 49) == 0),
           ($urandom_range(0, 3) != 0),
           SEL_W'($urandom),
           ($urandom_range(0, 9) < 3),
           ($urandom_range(0, 4) == 0),
           SEL_W'($urandom),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 9) == 0));
    end

    // Drain and confirm every expected result was delivered.
    repeat (3) idle(1, 0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
